// File: rtl/step_coordinator.sv
// ---------------------------------------------------------------------------
// step_coordinator
//
// Sequencing controller for an adaptive-step ODE datapath. For every step it
// launches one full-step evaluation (h), then two half-step evaluations
// (h/2). It then waits for the step-size evaluation circuit to accept or
// reject the step. An accepted step advances simulation time and loads the
// next h. A rejected step reloads h and retries, up to MAX_RETRY times in a
// row. The last step is clipped so that time lands exactly on tEnd.
//
// Optional build macro:
//   STEP_COORD_HMIN_EN - adds parameter HMIN (default 1 LSB). A step smaller
//                        than HMIN, or a non-positive step, before tEnd is
//                        reached raises a time/hmin fault. Without the macro,
//                        a non-positive step ends the run (DONE) with tNow
//                        left unchanged, so the run cannot loop forever.
//
// Ports:
//   Clk          in   system clock
//   reset        in   asynchronous active-low reset
//   start        in   one-cycle pulse, begins a run from IDLE/DONE/ERROR
//   tEnd         in   end time (signed Qm.FRAC), sampled on start
//   hInit        in   initial step, sampled on start
//   odeDone      in   ODE solver finished the current evaluation (pulse)
//   stepFinish   in   verdict from the evaluation circuit is valid
//   incTime      in   with stepFinish: the step is accepted
//   hStepIn      in   next h (on accept) or retry h (on reject)
//   exceptionErr in   datapath overflow/divide fault
//   coord        out  phase code: 00 FULL, 10 HALF, 11 EVAL, 01 idle/stopped
//   enableCoord  out  high in FULL, HALF1, HALF2, EVAL
//   odeStart     out  one-cycle pulse that launches an ODE evaluation
//   odeH         out  step handed to the ODE solver (h or h>>>1)
//   hStep        out  current h register
//   tNow         out  current simulation time
//   stepCount    out  number of accepted steps
//   busy         out  a run is in progress
//   done         out  run completed
//   error        out  run stopped on a fault
//   errCode      out  00 none, 01 exceptionErr, 10 retry limit,
//                     11 time overflow / hmin
// ---------------------------------------------------------------------------
module step_coordinator #(
  parameter int WIDTH     = 16,
  parameter int FRAC      = 8,
  parameter int MAX_RETRY = 7,
  parameter int CNT_W     = 16
`ifdef STEP_COORD_HMIN_EN
  ,
  parameter logic signed [WIDTH-1:0] HMIN = 1
`endif
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] tEnd,
  input  logic [WIDTH-1:0] hInit,
  input  logic             odeDone,
  input  logic             stepFinish,
  input  logic             incTime,
  input  logic [WIDTH-1:0] hStepIn,
  input  logic             exceptionErr,
  output logic [1:0]       coord,
  output logic             enableCoord,
  output logic             odeStart,
  output logic [WIDTH-1:0] odeH,
  output logic [WIDTH-1:0] hStep,
  output logic [WIDTH-1:0] tNow,
  output logic [CNT_W-1:0] stepCount,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [1:0]       errCode
);

  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  // The binary point has to sit inside the data word. The datapath here only
  // adds, subtracts and halves, so FRAC does not change any logic. It is kept
  // so that the whole ODE datapath shares one format definition.
  if (FRAC < 0 || FRAC >= WIDTH) begin : g_frac_out_of_range
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLIP,
    S_FULL,
    S_HALF1,
    S_HALF2,
    S_EVAL,
    S_DONE,
    S_ERROR
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_EXC   = 2'b01,
    ERR_RETRY = 2'b10,
    ERR_TIME  = 2'b11
  } err_t;

  // Status outputs that depend only on the state. They are registered
  // together with the state, so no output glitches on a state change.
  typedef struct packed {
    logic [1:0] coord;
    logic       en;
    logic       busy;
    logic       done;
    logic       error;
  } outs_t;

  function automatic outs_t outs_of(input state_t s);
    outs_t o;
    o = '{coord: 2'b01, en: 1'b0, busy: 1'b0, done: 1'b0, error: 1'b0};
    case (s)
      S_CLIP:  o.busy = 1'b1;
      S_FULL:  begin o.coord = 2'b00; o.en = 1'b1; o.busy = 1'b1; end
      S_HALF1: begin o.coord = 2'b10; o.en = 1'b1; o.busy = 1'b1; end
      S_HALF2: begin o.coord = 2'b10; o.en = 1'b1; o.busy = 1'b1; end
      S_EVAL:  begin o.coord = 2'b11; o.en = 1'b1; o.busy = 1'b1; end
      S_DONE:  o.done  = 1'b1;
      S_ERROR: o.error = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  state_t                   r_state;
  outs_t                    r_outs;
  logic                     r_ode_start;
  logic signed [WIDTH-1:0]  r_ode_h;
  logic signed [WIDTH-1:0]  r_t;
  logic signed [WIDTH-1:0]  r_h;
  logic signed [WIDTH-1:0]  r_tend;
  logic        [CNT_W-1:0]  r_cnt;
  logic        [RETRY_W-1:0] r_retry;
  err_t                     r_err;

  // Time arithmetic uses one guard bit. This makes the overflow test and the
  // "does this step pass tEnd" compare exact, even near the top of the range.
  logic signed [WIDTH:0]    w_sum;
  logic signed [WIDTH:0]    w_tend_ext;
  logic                     w_sum_ovf;
  logic                     w_past_end;
  logic                     w_t_reached;
  logic                     w_h_nonpos;
  logic signed [WIDTH-1:0]  w_remain;

  assign w_sum       = {r_t[WIDTH-1], r_t} + {r_h[WIDTH-1], r_h};
  assign w_tend_ext  = {r_tend[WIDTH-1], r_tend};
  assign w_sum_ovf   = w_sum[WIDTH] ^ w_sum[WIDTH-1];
  assign w_past_end  = w_sum > w_tend_ext;
  assign w_t_reached = r_t >= r_tend;
  assign w_h_nonpos  = r_h[WIDTH-1] || (r_h == '0);
  // Only used after t < tEnd is known and t >= 0, so the difference fits.
  assign w_remain    = r_tend - r_t;

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_outs      <= outs_of(S_IDLE);
      r_ode_start <= 1'b0;
      r_ode_h     <= '0;
      r_t         <= '0;
      r_h         <= '0;
      r_tend      <= '0;
      r_cnt       <= '0;
      r_retry     <= '0;
      r_err       <= ERR_NONE;
    end else begin
      // NOTE: state is updated with non-blocking assignments. Every right-hand
      // side therefore reads the value from before this edge, and a later
      // assignment to the same register in this block overrides this default.
      r_ode_start <= 1'b0;

      if (r_outs.busy && exceptionErr) begin
        // A datapath fault takes priority over every other transition.
        r_state <= S_ERROR;
        r_outs  <= outs_of(S_ERROR);
        r_err   <= ERR_EXC;
      end else begin
        case (r_state)
          S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
              r_t     <= '0;
              r_h     <= hInit;
              r_tend  <= tEnd;
              r_cnt   <= '0;
              r_retry <= '0;
              r_err   <= ERR_NONE;
              r_state <= S_CLIP;
              r_outs  <= outs_of(S_CLIP);
            end
          end

          S_CLIP: begin
            if (w_t_reached) begin
              r_state <= S_DONE;
              r_outs  <= outs_of(S_DONE);
`ifdef STEP_COORD_HMIN_EN
            end else if (w_h_nonpos || (r_h < HMIN)) begin
              r_state <= S_ERROR;
              r_outs  <= outs_of(S_ERROR);
              r_err   <= ERR_TIME;
`else
            end else if (w_h_nonpos) begin
              // A step that cannot advance time would loop forever, so the
              // run ends here with time left where it is.
              r_state <= S_DONE;
              r_outs  <= outs_of(S_DONE);
`endif
            end else begin
              r_state     <= S_FULL;
              r_outs      <= outs_of(S_FULL);
              r_ode_start <= 1'b1;
              if (w_past_end) begin
                r_h     <= w_remain;
                r_ode_h <= w_remain;
              end else begin
                r_ode_h <= r_h;
              end
            end
          end

          S_FULL: begin
            if (odeDone) begin
              r_state     <= S_HALF1;
              r_outs      <= outs_of(S_HALF1);
              r_ode_start <= 1'b1;
              r_ode_h     <= r_h >>> 1;
            end
          end

          S_HALF1: begin
            if (odeDone) begin
              r_state     <= S_HALF2;
              r_outs      <= outs_of(S_HALF2);
              r_ode_start <= 1'b1;
            end
          end

          S_HALF2: begin
            if (odeDone) begin
              r_state <= S_EVAL;
              r_outs  <= outs_of(S_EVAL);
            end
          end

          S_EVAL: begin
            if (stepFinish) begin
              if (incTime) begin
                if (w_sum_ovf) begin
                  // An accepted step that would wrap time is a fault. Time
                  // and the counters keep their last good values.
                  r_state <= S_ERROR;
                  r_outs  <= outs_of(S_ERROR);
                  r_err   <= ERR_TIME;
                end else begin
                  r_t     <= w_sum[WIDTH-1:0];
                  r_cnt   <= r_cnt + CNT_W'(1);
                  r_retry <= '0;
                  r_h     <= hStepIn;
                  r_state <= S_CLIP;
                  r_outs  <= outs_of(S_CLIP);
                end
              end else begin
                r_h     <= hStepIn;
                r_retry <= r_retry + RETRY_W'(1);
                if (r_retry == RETRY_W'(MAX_RETRY - 1)) begin
                  r_state <= S_ERROR;
                  r_outs  <= outs_of(S_ERROR);
                  r_err   <= ERR_RETRY;
                end else begin
                  // A retry goes straight back to FULL. The reloaded h is not
                  // clipped again.
                  r_state     <= S_FULL;
                  r_outs      <= outs_of(S_FULL);
                  r_ode_start <= 1'b1;
                  r_ode_h     <= hStepIn;
                end
              end
            end
          end

          default: begin
            r_state <= S_IDLE;
            r_outs  <= outs_of(S_IDLE);
          end
        endcase
      end
    end
  end

  assign coord       = r_outs.coord;
  assign enableCoord = r_outs.en;
  assign busy        = r_outs.busy;
  assign done        = r_outs.done;
  assign error       = r_outs.error;
  assign odeStart    = r_ode_start;
  assign odeH        = r_ode_h;
  assign hStep       = r_h;
  assign tNow        = r_t;
  assign stepCount   = r_cnt;
  assign errCode     = r_err;

endmodule

// File: tb/tb_step_coordinator.sv
module tb_step_coordinator;

  localparam int MAX_RETRY = 7;

  logic        Clk = 1'b0;
  logic        reset, start, odeDone, stepFinish, incTime, exceptionErr;
  logic [15:0] tEnd, hInit, hStepIn;
  logic [1:0]  coord, errCode;
  logic        enableCoord, odeStart, busy, done, error;
  logic [15:0] odeH, hStep, tNow, stepCount;

  int total = 0;
  int bad   = 0;

  step_coordinator dut (
    .Clk(Clk), .reset(reset), .start(start), .tEnd(tEnd), .hInit(hInit),
    .odeDone(odeDone), .stepFinish(stepFinish), .incTime(incTime),
    .hStepIn(hStepIn), .exceptionErr(exceptionErr), .coord(coord),
    .enableCoord(enableCoord), .odeStart(odeStart), .odeH(odeH),
    .hStep(hStep), .tNow(tNow), .stepCount(stepCount), .busy(busy),
    .done(done), .error(error), .errCode(errCode)
  );

  always #5 Clk = ~Clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge Clk);
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (odeStart !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    check({tag, " odeStart"}, odeStart, 1);
  endtask

  task automatic pulse_done;
    repeat ($urandom_range(2)) tick;
    odeDone = 1'b1;
    tick;
    odeDone = 1'b0;
  endtask

  // One full/half/half/eval cycle as seen by the solver and the evaluator.
  task automatic step_once(input int exp_h, input bit acc, input int hnext);
    wait_start("FULL");
    check("FULL coord", coord, 2'b00);
    check("FULL odeH", odeH, exp_h);
    check("FULL enable", enableCoord, 1);
    tick;
    check("odeStart width", odeStart, 0);
    if ($urandom_range(1) == 1) begin
      // A verdict outside EVAL must be ignored.
      stepFinish = 1'b1; incTime = 1'b1; hStepIn = 16'h1234;
      tick;
      stepFinish = 1'b0; incTime = 1'b0;
    end
    pulse_done;
    wait_start("HALF1");
    check("HALF1 coord", coord, 2'b10);
    check("HALF1 odeH", odeH, exp_h / 2);
    pulse_done;
    wait_start("HALF2");
    check("HALF2 coord", coord, 2'b10);
    check("HALF2 odeH", odeH, exp_h / 2);
    pulse_done;
    check("EVAL coord", coord, 2'b11);
    if ($urandom_range(1) == 1) begin
      odeDone = 1'b1;
      tick;
      odeDone = 1'b0;
      check("EVAL ignores odeDone", coord, 2'b11);
    end
    stepFinish = 1'b1; incTime = acc; hStepIn = 16'(hnext);
    tick;
    stepFinish = 1'b0; incTime = 1'b0;
  endtask

  // One whole run checked against a plain-arithmetic model of time and step.
  // mode 0: always accept with hfix; 1: accept twice, then reject with hfix;
  // 2: random; 3: reject once, then accept with hfix; 4: overflow scenario.
  task automatic run(input int tend, input int hinit, input int mode, input int hfix);
    int mt, mh, mc, mr, hn;
    bit acc, from_clip;
    mt = 0; mh = hinit; mc = 0; mr = 0; from_clip = 1'b1;
    tEnd = 16'(tend); hInit = 16'(hinit);
    start = 1'b1;
    tick;
    start = 1'b0;
    check("start tNow", tNow, 0);
    check("start stepCount", stepCount, 0);
    check("start hStep", hStep, hinit);
    check("start busy", busy, 1);
    check("start errCode", errCode, 0);
    for (int it = 0; it < 400; it++) begin
      if (from_clip) begin
        if (mt >= tend || mh <= 0) begin
          tick;
          check("end done", done, 1);
          check("end error", error, 0);
          check("end busy", busy, 0);
          check("end coord", coord, 2'b01);
          check("end tNow", tNow, mt);
          check("end stepCount", stepCount, mc);
          check("end hStep", hStep, mh & 16'hffff);
          return;
        end
        if (mt + mh > tend) mh = tend - mt;
      end
      case (mode)
        0: begin acc = 1'b1; hn = hfix; end
        1: begin acc = (mc < 2); hn = hfix; end
        2: begin
          acc = ($urandom_range(3) != 0);
          hn  = ($urandom_range(15) == 0) ? 0 : int'($urandom_range(256, 16));
        end
        3: begin acc = (it != 0); hn = hfix; end
        default: begin
          acc = (it != 1);
          hn  = (it == 0) ? 'h7000 : (it == 1) ? 'h7fff : 'h10;
        end
      endcase
      step_once(mh, acc, hn);
      if (acc && mt + mh > 32767) begin
        check("ovf error", error, 1);
        check("ovf errCode", errCode, 2'b11);
        check("ovf tNow", tNow, mt);
        check("ovf stepCount", stepCount, mc);
        return;
      end
      if (acc) begin
        mt += mh; mc++; mr = 0; from_clip = 1'b1;
      end else begin
        mr++; from_clip = 1'b0;
      end
      mh = hn;
      check("step tNow", tNow, mt);
      check("step stepCount", stepCount, mc);
      check("step hStep", hStep, hn);
      if (mr == MAX_RETRY) begin
        check("retry error", error, 1);
        check("retry errCode", errCode, 2'b10);
        check("retry coord", coord, 2'b01);
        check("retry busy", busy, 0);
        return;
      end
    end
    check("run ended within bound", done | error, 1);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; odeDone = 1'b0; stepFinish = 1'b0;
    incTime = 1'b0; exceptionErr = 1'b0;
    tEnd = '0; hInit = '0; hStepIn = '0;
    repeat (3) tick;
    check("reset coord", coord, 2'b01);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset error", error, 0);
    check("reset odeStart", odeStart, 0);
    check("reset tNow", tNow, 0);
    check("reset hStep", hStep, 0);
    reset = 1'b1;
    tick;

    run('h100, 'h40, 0, 'h40);   // four equal steps
    run('h100, 'h60, 0, 'h60);   // last step clipped to 0x40
    run('h100, 'h40, 3, 'h20);   // single reject, then accepts
    run('h100, 'h40, 1, 'h30);   // retry limit after two accepts
    run('h7fff, 'h7000, 4, 0);   // accepted step wraps time

    // exceptionErr in HALF2; start while busy is ignored.
    tEnd = 16'h100; hInit = 16'h40;
    start = 1'b1;
    tick;
    start = 1'b0;
    step_once('h40, 1'b1, 'h40);
    wait_start("exc FULL");
    hInit = 16'h10; start = 1'b1;
    tick;
    start = 1'b0;
    check("busy start ignored", hStep, 16'h40);
    pulse_done;
    wait_start("exc HALF1");
    pulse_done;
    wait_start("exc HALF2");
    exceptionErr = 1'b1;
    tick;
    exceptionErr = 1'b0;
    check("exc error", error, 1);
    check("exc errCode", errCode, 2'b01);
    check("exc coord", coord, 2'b01);
    check("exc enable", enableCoord, 0);
    check("exc tNow", tNow, 16'h40);
    repeat (3) tick;
    check("exc sticky", error, 1);
    run('h100, 'h40, 0, 'h40);   // clean restart from t=0

    run(0, 'h40, 0, 'h40);       // already at tEnd
    run('h100, 0, 0, 'h40);      // zero step ends the run, time unchanged
    for (int r = 0; r < 6; r++)
      run(int'($urandom_range('h400, 'h80)), int'($urandom_range('h100, 'h10)), 2, 0);

    // Asynchronous reset in EVAL, then a stray odeDone after release.
    tEnd = 16'h100; hInit = 16'h40;
    start = 1'b1;
    tick;
    start = 1'b0;
    step_once('h40, 1'b1, 'h40);
    wait_start("rst FULL");
    pulse_done;
    wait_start("rst HALF1");
    pulse_done;
    wait_start("rst HALF2");
    pulse_done;
    check("rst pre coord", coord, 2'b11);
    check("rst pre tNow", tNow, 16'h40);
    #2 reset = 1'b0;
    #1;
    check("rst async coord", coord, 2'b01);
    check("rst async busy", busy, 0);
    check("rst async enable", enableCoord, 0);
    check("rst async tNow", tNow, 0);
    check("rst async hStep", hStep, 0);
    check("rst async stepCount", stepCount, 0);
    check("rst async odeH", odeH, 0);
    check("rst async errCode", errCode, 0);
    odeDone = 1'b1;
    tick;
    reset = 1'b1;
    tick;
    odeDone = 1'b0;
    check("rst post busy", busy, 0);
    check("rst post coord", coord, 2'b01);
    check("rst post odeStart", odeStart, 0);
    tick;
    check("rst post idle", busy | done | error, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/step_coordinator.md
Name: step_coordinator

Overview:
Sequencing controller for the adaptive-step ODE datapath; the step-size evaluation circuit is the responder it drives. Drives the 2-bit phase code, launches ODE solver evaluations for one full step h and two half steps h/2, then waits for the accept/reject verdict. Advances simulation time on accept, reloads h on reject, clips the final step to land exactly on tEnd, and reports completion or fault.

Parameters:
WIDTH, 16, data width of time and step values (signed fixed point)
FRAC, 8, fractional bits (Q8.8 at defaults)
MAX_RETRY, 7, max consecutive rejected steps before fault
CNT_W, 16, width of accepted-step counter

Ports:
Clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins a run when IDLE/DONE/ERROR
tEnd  in  WIDTH  end time; sampled on start
hInit  in  WIDTH  initial step; sampled on start
odeDone  in  1  ODE solver finished current evaluation (1-cycle pulse)
stepFinish  in  1  evaluation circuit verdict valid
incTime  in  1  with stepFinish: step accepted
hStepIn  in  WIDTH  next/retry h from evaluation circuit
exceptionErr  in  1  datapath overflow/div fault
coord  out  2  phase code: 00 FULL, 10 HALF, 11 EVAL, 01 idle/stopped
enableCoord  out  1  high in FULL, HALF1, HALF2, EVAL
odeStart  out  1  one-cycle pulse launching an ODE evaluation
odeH  out  WIDTH  step for ODE: h in FULL, h>>>1 in HALF1/HALF2
hStep  out  WIDTH  current h register
tNow  out  WIDTH  current simulation time
stepCount  out  CNT_W  accepted steps
busy  out  1  not IDLE/DONE/ERROR
done  out  1  high in DONE
error  out  1  high in ERROR
errCode  out  2  00 none, 01 exceptionErr, 10 retry limit, 11 time overflow/hmin

Behaviour:
- Reset (async, reset==0): state IDLE, coord=01, all data outputs 0, odeStart/done/error/busy 0, errCode 00, retry counter 0.
- States: IDLE, CLIP, FULL, HALF1, HALF2, EVAL, DONE, ERROR.
- IDLE/DONE/ERROR + start: t<=0, h<=hInit, stepCount<=0, retry<=0, errCode<=00 -> CLIP. start is ignored while busy.
- CLIP (1 cycle): if t>=tEnd -> DONE; else if t+h>tEnd then h<=tEnd-t; -> FULL.
- FULL: odeStart pulses on the first cycle in state. Wait odeDone -> HALF1.
- HALF1: odeStart on entry; odeDone -> HALF2. HALF2: same; odeDone -> EVAL.
- EVAL: wait stepFinish.
  - stepFinish & incTime: t<=t+h, stepCount++, retry<=0, h<=hStepIn -> CLIP.
  - stepFinish & !incTime: h<=hStepIn, retry++. If retry reaches MAX_RETRY -> ERROR(10); else -> FULL.
- odeDone in EVAL or stepFinish outside EVAL: ignored.
- exceptionErr in any busy state has priority over every other transition -> ERROR(01) next cycle.
- t+h signed overflow on accept -> ERROR(11); t is not updated.
- ERROR and DONE are sticky until start or reset. tNow, hStep and stepCount hold their values.
- Reset low mid-run: immediate return to IDLE values; any in-flight odeDone is ignored after release.
- Latency: start to first odeStart is 2 cycles (capture, CLIP). Accept to next odeStart is 2 cycles.

Optional Feature:
STEP_COORD_HMIN_EN: when defined, adds parameter HMIN (default 1 LSB). In CLIP, if h<HMIN or h<=0 while t<tEnd -> ERROR(11). When undefined, there is no minimum check, and h<=0 in CLIP -> DONE with tNow unchanged to avoid a livelock.

Test Plan:
- hInit=0x0040, tEnd=0x0100, every EVAL answers incTime=1, hStepIn=0x0040 -> 4 accepts, coord cycles 00,10,10,11 per step, tNow=0x0100, stepCount=4, done=1.
- hInit=0x0060, tEnd=0x0100, hStepIn=0x0060 -> accepted h values 0x0060, 0x0060, 0x0040 (clipped), tNow=0x0100, stepCount=3.
- Single reject: stepFinish=1, incTime=0, hStepIn=0x0020 -> no t change, hStep=0x0020, FULL re-entered with odeH=0x0020; then accept -> tNow=0x0020.
- 7 consecutive rejects (MAX_RETRY=7) -> error=1, errCode=10, coord=01, stepCount unchanged.
- exceptionErr pulsed during HALF2 -> next cycle ERROR, errCode=01; a later start restarts cleanly from tNow=0.
- reset asserted low during EVAL -> all outputs 0 asynchronously; odeDone pulse after release leaves state IDLE.
